// File: rtl/step_gen_pkg.sv
// step_gen_pkg: shared types and helpers for the step profile generator.
//   state_t       : move sequencer states
//   IDX_*         : word positions inside the five-word parameter array
//   word_t        : 32-bit parameter / period word
//   clamp_period  : clamp a 33-bit signed period to [min_p, 2^32-1]
//   ramp_len      : ramp length min(nn, n>>1)
package step_gen_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        ACCEL,
        CRUISE,
        DECEL,
        DONE
    } state_t;

    localparam int unsigned IDX_N     = 0;
    localparam int unsigned IDX_NN    = 1;
    localparam int unsigned IDX_T0    = 2;
    localparam int unsigned IDX_TNA   = 3;
    localparam int unsigned IDX_DELTA = 4;

    // A 33-bit signed value never exceeds 2^32-1, so only the lower bound
    // needs an explicit test.
    function automatic word_t clamp_period(input logic signed [32:0] x,
                                           input word_t              min_p);
        if (x < $signed({1'b0, min_p})) begin
            return min_p;
        end
        return word_t'(x[31:0]);
    endfunction

    function automatic word_t ramp_len(input word_t n, input word_t nn);
        return (nn < (n >> 1)) ? nn : (n >> 1);
    endfunction

endpackage

// File: rtl/step_period_timer.sv
// step_period_timer: plays out one step period per start strobe.
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   start_i       : load period_i and begin a new period next cycle
//   kill_i        : stop the running period immediately at the next edge
//   period_i      : period length in cycles (>= 1)
//   level_o       : step level, high for the first PULSE_WIDTH cycles
//   period_end_o  : high in the last cycle of the running period
module step_period_timer
    import step_gen_pkg::*;
#(
    parameter int unsigned PULSE_WIDTH = 8
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  start_i,
    input  logic  kill_i,
    input  word_t period_i,
    output logic  level_o,
    output logic  period_end_o
);

    word_t cnt_q;
    word_t per_q;
    logic  active_q;

    always_comb begin
        period_end_o = active_q && (cnt_q == (per_q - 32'd1));
        level_o      = active_q && (cnt_q < word_t'(PULSE_WIDTH));
    end

    // A start coinciding with period_end reloads directly, giving
    // back-to-back periods with no idle cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            per_q    <= '0;
            active_q <= 1'b0;
        end else if (kill_i) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (start_i) begin
            cnt_q    <= '0;
            per_q    <= period_i;
            active_q <= 1'b1;
        end else if (period_end_o) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (active_q) begin
            cnt_q    <= cnt_q + 32'd1;
        end
    end

endmodule

// File: rtl/step_profile_generator.sv
// step_profile_generator: trapezoidal step-pulse profile generator.
//   clk, reset   : clock, asynchronous active-high reset
//   param_valid  : parameter set valid level; a rising edge starts a move
//   par[0:4]     : N, nn, t0, tna, delta (delta signed)
//   abort        : synchronous stop request
//   step         : step pulse output
//   busy         : move in progress
//   done         : one-cycle completion strobe
//   step_count   : step pulses issued in the current move
module step_profile_generator
    import step_gen_pkg::*;
#(
    parameter int unsigned PULSE_WIDTH = 8,
    parameter int unsigned MIN_PERIOD  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        param_valid,
    input  logic [31:0] par [0:4],
    input  logic        abort,
    output logic        step,
    output logic        busy,
    output logic        done,
    output logic [31:0] step_count
);

    localparam word_t MIN_P = word_t'(MIN_PERIOD);

    state_t state_q, state_d;
    logic   valid_q;
    word_t  par_q [0:4];
    word_t  idx_q, idx_d;       // steps issued in the current phase
    word_t  rper_q, rper_d;     // last ramp period, reused to start DECEL
    word_t  cnt_q, cnt_d;

    logic   accept;
    logic   start;
    logic   kill;
    word_t  next_per;
    word_t  n_w, nn_w, ramp_w, cruise_w;
    logic signed [32:0] delta_s;
    logic   tmr_level, tmr_end;

    step_period_timer #(
        .PULSE_WIDTH (PULSE_WIDTH)
    ) u_timer (
        .clk_i        (clk),
        .rst_i        (reset),
        .start_i      (start),
        .kill_i       (kill),
        .period_i     (next_per),
        .level_o      (tmr_level),
        .period_end_o (tmr_end)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            idx_q   <= '0;
            rper_q  <= '0;
            cnt_q   <= '0;
            for (int unsigned i = 0; i < 5; i++) begin
                par_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            valid_q <= param_valid;
            idx_q   <= idx_d;
            rper_q  <= rper_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                for (int unsigned i = 0; i < 5; i++) begin
                    par_q[i] <= par[i];
                end
            end
        end
    end

    always_comb begin
        // In IDLE the move geometry comes straight from the inputs so the
        // first period can be launched in the accept cycle.
        n_w      = (state_q == IDLE) ? par[IDX_N]  : par_q[IDX_N];
        nn_w     = (state_q == IDLE) ? par[IDX_NN] : par_q[IDX_NN];
        ramp_w   = ramp_len(n_w, nn_w);
        cruise_w = n_w - (ramp_w << 1);
        delta_s  = {par_q[IDX_DELTA][31], par_q[IDX_DELTA]};
        accept   = (state_q == IDLE) && param_valid && !valid_q && !abort;

        state_d  = state_q;
        idx_d    = idx_q;
        rper_d   = rper_q;
        cnt_d    = cnt_q;
        start    = 1'b0;
        next_per = rper_q;
        kill     = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d = '0;
                    if (n_w == '0) begin
                        state_d = DONE;
                    end else if (ramp_w != '0) begin
                        state_d  = ACCEL;
                        next_per = clamp_period({1'b0, par[IDX_T0]}, MIN_P);
                        rper_d   = next_per;
                        idx_d    = 32'd1;
                        start    = 1'b1;
                    end else begin
                        state_d  = CRUISE;
                        next_per = clamp_period({1'b0, par[IDX_TNA]}, MIN_P);
                        idx_d    = 32'd1;
                        start    = 1'b1;
                    end
                end
            end
            ACCEL: begin
                if (tmr_end) begin
                    start = 1'b1;
                    if (idx_q < ramp_w) begin
                        next_per = clamp_period($signed({1'b0, rper_q}) + delta_s, MIN_P);
                        rper_d   = next_per;
                        idx_d    = idx_q + 32'd1;
                    end else if (cruise_w != '0) begin
                        state_d  = CRUISE;
                        next_per = clamp_period({1'b0, par_q[IDX_TNA]}, MIN_P);
                        idx_d    = 32'd1;
                    end else begin
                        state_d  = DECEL;
                        next_per = rper_q;
                        idx_d    = 32'd1;
                    end
                end
            end
            CRUISE: begin
                if (tmr_end) begin
                    if (idx_q < cruise_w) begin
                        next_per = clamp_period({1'b0, par_q[IDX_TNA]}, MIN_P);
                        idx_d    = idx_q + 32'd1;
                        start    = 1'b1;
                    end else if (ramp_w != '0) begin
                        state_d  = DECEL;
                        next_per = rper_q;
                        idx_d    = 32'd1;
                        start    = 1'b1;
                    end else begin
                        state_d  = DONE;
                    end
                end
            end
            DECEL: begin
                if (tmr_end) begin
                    if (idx_q < ramp_w) begin
                        next_per = clamp_period($signed({1'b0, rper_q}) - delta_s, MIN_P);
                        rper_d   = next_per;
                        idx_d    = idx_q + 32'd1;
                        start    = 1'b1;
                    end else begin
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (start) begin
            cnt_d = cnt_d + 32'd1;
        end

        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            start   = 1'b0;
            kill    = 1'b1;
            cnt_d   = cnt_q;
        end
    end

    always_comb begin
        busy       = (state_q == ACCEL) || (state_q == CRUISE) || (state_q == DECEL);
        done       = (state_q == DONE);
        step       = tmr_level && !abort;
        step_count = cnt_q;
    end

endmodule

// File: doc/step_profile_generator.md
STEP_PROFILE_GENERATOR -- requirements
Module: step_profile_generator

Interface
REQ-001 SHALL have parameter PULSE_WIDTH, default 8: step pulse high time in clk cycles.
REQ-002 SHALL have parameter MIN_PERIOD, default 16: lower clamp on any step period in clk cycles; must be greater than PULSE_WIDTH.
REQ-003 clk  in  1  single system clock, all logic on posedge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 param_valid  in  1  level from the upstream parameter calculator; high while the parameter set is valid.
REQ-006 par  in  32 x5 array [0:4]  N, nn, t0, tna, delta; delta is two's-complement signed, all others unsigned.
REQ-007 abort  in  1  synchronous stop request.
REQ-008 step  out  1  step pulse to the driver.
REQ-009 busy  out  1  high from acceptance until completion or abort.
REQ-010 done  out  1  one-cycle completion strobe.
REQ-011 step_count  out  32  number of step pulses issued in the current move.

Function
REQ-012 SHALL accept a move only on a rising edge of param_valid (valid high, previous-cycle valid low) while in IDLE; all five par words latched that cycle; a level held high SHALL NOT retrigger.
REQ-013 SHALL compute the ramp length on acceptance: ramp = min(nn, N>>1); cruise = N - 2*ramp.
REQ-014 SHALL use states IDLE, ACCEL, CRUISE, DECEL, DONE; IDLE->ACCEL on accept (ramp>0), IDLE->CRUISE on accept (ramp=0, N>0), IDLE->DONE on accept (N=0); ACCEL->CRUISE after ramp steps, or ->DECEL when cruise=0; CRUISE->DECEL after cruise steps, or ->DONE when ramp=0; DECEL->DONE after ramp steps; DONE->IDLE unconditionally after one cycle.
REQ-015 Period rules: the first ACCEL step SHALL use t0; each later ACCEL step SHALL use previous + delta; CRUISE steps SHALL use tna; the first DECEL step SHALL use the last ACCEL period; each later DECEL step SHALL use previous - delta.
REQ-016 Period arithmetic SHALL be 33-bit signed; results SHALL be clamped to [MIN_PERIOD, 2^32-1], and every selected period, t0 and tna included, SHALL be clamped the same way.
REQ-017 Each step SHALL occupy exactly its period P cycles; step SHALL be high for the first PULSE_WIDTH cycles of the period and low for the remainder.
REQ-018 Timing: the first step rising edge SHALL occur the cycle after acceptance; step pulses SHALL be back-to-back with no idle gap between periods.
REQ-019 step_count SHALL clear on acceptance and increment on each step rising edge; it SHALL hold its value after done until the next accept.
REQ-020 done SHALL pulse in the DONE state, the cycle after the last cycle of the final period, or the cycle after acceptance when N=0; busy SHALL fall in the same cycle.
REQ-021 abort SHALL force IDLE on the next edge, step low immediately and busy low, with no done pulse; abort in IDLE has no effect.
REQ-022 If abort and a param_valid rising edge occur in the same cycle, abort SHALL win and the move SHALL NOT be accepted.

Reset
REQ-023 While reset is high: state IDLE; step, busy and done 0; step_count 0; latched parameters 0; edge-detect register 0.
REQ-024 Reset asserted mid-move SHALL end the pulse immediately and asynchronously; no done pulse is produced.

Structure
REQ-025 Package step_gen_pkg SHALL hold the state enum, the par index constants (IDX_N=0, IDX_NN=1, IDX_T0=2, IDX_TNA=3, IDX_DELTA=4) and the 32-bit word typedef.
REQ-026 Sub-module step_period_timer SHALL take a period load with a start strobe and produce the step level and a period_end strobe.

Verification
REQ-027 N=0 -> done on the cycle after accept; no step pulses; step_count 0.
REQ-028 N=10, nn=3, t0=100, tna=40, delta=-20 -> periods 100,80,60,40,40,40,40,60,80,100 with 3 ACCEL, 4 CRUISE and 3 DECEL steps; step_count 10; done after 640 cycles of stepping.
REQ-029 N=4, nn=5 -> ramp 2, cruise 0; transition ACCEL->DECEL; periods t0, t0+delta, t0+delta, t0.
REQ-030 t0=20, delta=-10 -> the second period clamps to 16; no negative or zero period occurs.
REQ-031 abort asserted after the 3rd step of N=10 -> step low immediately, busy low on the next edge, no done pulse; a later new rising edge of param_valid starts a fresh move.
REQ-032 param_valid held high across done -> no second move; dropping valid and raising it again starts a new move.
